// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone burst master.
//   wb_state_e : burst FSM states (IDLE, WDAT, REQ, GAP)
//   WB_ADR_W   : default Wishbone address width
//   WB_DAT_W   : default Wishbone data width
package wb_pkg;

  localparam int WB_ADR_W = 12;
  localparam int WB_DAT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WDAT = 2'd1,
    ST_REQ  = 2'd2,
    ST_GAP  = 2'd3
  } wb_state_e;

endpackage

// File: rtl/wb_burst_master_if.sv
// Wishbone classic master/slave signal bundle for the burst master.
//   adr_o, we_o, stb_o, cyc_o, dat_o : driven by the master
//   dat_i, ack_i                     : driven by the slave
// Modports: master (drives the request side), slave (drives the response side).
interface wb_burst_master_if
  import wb_pkg::*;
#(
  parameter int ADR_W = WB_ADR_W,
  parameter int DAT_W = WB_DAT_W
) ();

  logic [ADR_W-1:0] adr_o;
  logic             we_o;
  logic             stb_o;
  logic             cyc_o;
  logic [DAT_W-1:0] dat_o;
  logic [DAT_W-1:0] dat_i;
  logic             ack_i;

  modport master (
    output adr_o, we_o, stb_o, cyc_o, dat_o,
    input  dat_i, ack_i
  );

  modport slave (
    input  adr_o, we_o, stb_o, cyc_o, dat_o,
    output dat_i, ack_i
  );

endinterface

// File: rtl/wb_timeout_cnt.sv
// Ack timeout counter for the burst master (used only when
// WB_BURST_TIMEOUT_EN is defined).
//   clk_i    : clock
//   rst_i    : synchronous active-low reset
//   run_i    : master is in REQ waiting for ack; counter clears whenever low
//   ack_i    : Wishbone ack
//   expire_o : this REQ cycle is the TMO_CYC-th one without ack
module wb_timeout_cnt #(
  parameter int TMO_CYC = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  input  logic ack_i,
  output logic expire_o
);

  localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

  logic [7:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q <= 8'd0;
    end else if (!run_i) begin
      cnt_q <= 8'd0;
    end else if (!ack_i) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  // Flags the cycle whose edge would bring the count to TMO_CYC, so the
  // FSM's registered err lands exactly TMO_CYC cycles after stb_o rose.
  assign expire_o = run_i && !ack_i && (cnt_q == TMO_LAST);

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone burst master: accepts a burst command (start address, direction,
// 1..16 beats), streams write beats from wdat or returns read beats on rdat,
// and pulses done at the end. Every ack is followed by one stb_o-low GAP
// cycle so that a slave holding ack high is never counted twice.
// Optional feature: define WB_BURST_TIMEOUT_EN to abort a beat after TMO_CYC
// ack-less REQ cycles (err pulse); otherwise err is tied low.
// Ports:
//   clk_i, rst_i                : clock, synchronous active-low reset
//   cmd_valid/cmd_ready         : command handshake (cmd_adr, cmd_we, cmd_len)
//   wdat/wdat_valid/wdat_ready  : write beat stream
//   rdat/rdat_valid             : read beat output (one-cycle pulse per beat)
//   done, err                   : one-cycle completion / timeout pulses
//   wb                          : Wishbone master modport
module wb_burst_master
  import wb_pkg::*;
#(
  parameter int ADR_W   = WB_ADR_W,
  parameter int DAT_W   = WB_DAT_W,
  parameter int TMO_CYC = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADR_W-1:0]  cmd_adr,
  input  logic              cmd_we,
  input  logic [3:0]        cmd_len,
  input  logic [DAT_W-1:0]  wdat,
  input  logic              wdat_valid,
  output logic              wdat_ready,
  output logic [DAT_W-1:0]  rdat,
  output logic              rdat_valid,
  output logic              done,
  output logic              err,
  wb_burst_master_if.master wb
);

  wb_state_e        state_q;
  logic [ADR_W-1:0] adr_q;
  logic [ADR_W-1:0] adr_d;
  logic             we_q;
  logic             stb_q;
  logic             cyc_q;
  logic [DAT_W-1:0] dat_q;
  logic [3:0]       len_q;
  logic [3:0]       beat_q;
  logic             cmd_ready_q;
  logic             wdat_ready_q;
  logic [DAT_W-1:0] rdat_q;
  logic             rdat_valid_q;
  logic             done_q;

  // Natural wrap at 2^ADR_W gives the required 0xFFF -> 0x000 rollover.
  assign adr_d = adr_q + ADR_W'(1);

`ifdef WB_BURST_TIMEOUT_EN
  logic err_q;
  logic tmo_expire;

  wb_timeout_cnt #(
    .TMO_CYC (TMO_CYC)
  ) u_timeout_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .run_i    (state_q == ST_REQ),
    .ack_i    (wb.ack_i),
    .expire_o (tmo_expire)
  );

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= ST_IDLE;
      adr_q        <= '0;
      we_q         <= 1'b0;
      stb_q        <= 1'b0;
      cyc_q        <= 1'b0;
      dat_q        <= '0;
      len_q        <= 4'd0;
      beat_q       <= 4'd0;
      cmd_ready_q  <= 1'b0;
      wdat_ready_q <= 1'b0;
      rdat_q       <= '0;
      rdat_valid_q <= 1'b0;
      done_q       <= 1'b0;
`ifdef WB_BURST_TIMEOUT_EN
      err_q        <= 1'b0;
`endif
    end else begin
      rdat_valid_q <= 1'b0;
      done_q       <= 1'b0;
`ifdef WB_BURST_TIMEOUT_EN
      err_q        <= 1'b0;
`endif
      unique case (state_q)
        ST_IDLE: begin
          // cmd_ready rises one cycle after entering IDLE, so it can never
          // coincide with the done/err pulse of the previous burst.
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            adr_q       <= cmd_adr;
            we_q        <= cmd_we;
            len_q       <= cmd_len;
            beat_q      <= 4'd0;
            cyc_q       <= 1'b1;
            if (cmd_we) begin
              state_q      <= ST_WDAT;
              wdat_ready_q <= 1'b1;
            end else begin
              state_q <= ST_REQ;
              stb_q   <= 1'b1;
            end
          end
        end

        ST_WDAT: begin
          if (wdat_valid && wdat_ready_q) begin
            dat_q        <= wdat;
            wdat_ready_q <= 1'b0;
            stb_q        <= 1'b1;
            state_q      <= ST_REQ;
          end
        end

        ST_REQ: begin
          if (wb.ack_i) begin
            stb_q   <= 1'b0;
            state_q <= ST_GAP;
            if (!we_q) begin
              rdat_q       <= wb.dat_i;
              rdat_valid_q <= 1'b1;
            end
`ifdef WB_BURST_TIMEOUT_EN
          end else if (tmo_expire) begin
            // Abort: remaining beats are discarded.
            stb_q   <= 1'b0;
            cyc_q   <= 1'b0;
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
`endif
          end
        end

        ST_GAP: begin
          if (beat_q != len_q) begin
            beat_q <= beat_q + 4'd1;
            adr_q  <= adr_d;
            if (we_q) begin
              state_q      <= ST_WDAT;
              wdat_ready_q <= 1'b1;
            end else begin
              state_q <= ST_REQ;
              stb_q   <= 1'b1;
            end
          end else begin
            cyc_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign wdat_ready = wdat_ready_q;
  assign rdat       = rdat_q;
  assign rdat_valid = rdat_valid_q;
  assign done       = done_q;

  assign wb.adr_o = adr_q;
  assign wb.we_o  = we_q;
  assign wb.stb_o = stb_q;
  assign wb.cyc_o = cyc_q;
  assign wb.dat_o = dat_q;

endmodule

// File: doc/wb_burst_master.md
WB_BURST_MASTER -- requirements
Module: wb_burst_master

Interface
REQ-001 Parameter ADR_W, default 12, Wishbone address width.
REQ-002 Parameter DAT_W, default 8, Wishbone data width.
REQ-003 Parameter TMO_CYC, default 255, ack timeout in clk_i cycles (1..255).
REQ-004 clk_i  in  1  single clock; all logic on rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-low.
REQ-006 cmd_valid  in  1  burst command offered.
REQ-007 cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
REQ-008 cmd_adr  in  ADR_W  start address.
REQ-009 cmd_we  in  1  1=write burst, 0=read burst.
REQ-010 cmd_len  in  4  beats minus one (0 gives 1 beat, 15 gives 16 beats).
REQ-011 wdat  in  DAT_W  write beat data.
REQ-012 wdat_valid  in  1  write data available.
REQ-013 wdat_ready  out  1  write beat consumed when wdat_valid & wdat_ready.
REQ-014 rdat  out  DAT_W  read beat data.
REQ-015 rdat_valid  out  1  one-cycle pulse per read beat.
REQ-016 done  out  1  one-cycle pulse, burst completed.
REQ-017 err  out  1  one-cycle pulse, burst aborted by timeout.
REQ-018 adr_o, we_o, stb_o, cyc_o, dat_o  out  ADR_W,1,1,1,DAT_W  Wishbone master outputs.
REQ-019 dat_i, ack_i  in  DAT_W,1  Wishbone master inputs.

Function
REQ-020 FSM states SHALL be IDLE, WDAT, REQ, GAP, with transitions only as in REQ-021..REQ-027.
REQ-021 IDLE: cmd_ready=1; on acceptance, latch adr/we/len, beat counter=0, go WDAT if write else REQ.
REQ-022 WDAT: wdat_ready=1; on wdat handshake latch dat_o, go REQ next cycle; cyc_o held 1 between beats, stb_o=0.
REQ-023 REQ: cyc_o=1, stb_o=1, adr_o/we_o/dat_o stable until ack_i sampled 1.
REQ-024 On ack_i in REQ for a read: rdat<=dat_i, rdat_valid pulses the following cycle.
REQ-025 After every ack, GAP SHALL drive stb_o=0 for exactly one cycle so that a level-held ack is never counted twice.
REQ-026 GAP: if beats remain, adr_o increments modulo 2^ADR_W (0xFFF wraps to 0x000), go WDAT (write) or REQ (read); else cyc_o=0, done pulses, go IDLE.
REQ-027 ack_i outside REQ SHALL be ignored.
REQ-028 Minimum read beat period SHALL be 3 cycles (REQ, ack cycle, GAP); cmd accept to first stb_o=1 SHALL be 1 cycle for reads.
REQ-029 cmd_ready SHALL be 0 in every state except IDLE; done and cmd acceptance in the same cycle are impossible by construction.

Reset
REQ-030 While rst_i=0 at a clock edge: state IDLE; cyc_o, stb_o, we_o, rdat_valid, done, err, wdat_ready = 0; adr_o, dat_o, rdat, counters = 0.
REQ-031 Reset mid-burst SHALL drop cyc_o/stb_o on the next edge with no done/err pulse and no further beats.

Configuration
REQ-032 With WB_BURST_TIMEOUT_EN defined: an 8-bit counter clears on REQ entry, increments each REQ cycle without ack; reaching TMO_CYC drops cyc_o/stb_o, pulses err, returns IDLE, discards remaining beats.
REQ-033 Without WB_BURST_TIMEOUT_EN: no counter, err tied to 0, REQ waits for ack indefinitely.

Structure
REQ-034 Shared package wb_pkg SHALL hold the FSM state enumeration and default ADR_W/DAT_W constants.
REQ-035 Timeout counter SHALL be a sub-module wb_timeout_cnt, instantiated only under WB_BURST_TIMEOUT_EN.

Verification
REQ-036 Single read: cmd_adr=0x010, len=0, slave returns 0xA5 with ack one cycle after stb -> rdat=0xA5 with one rdat_valid pulse, then done, cyc_o low.
REQ-037 Write burst: cmd_adr=0xFFE, len=3, wdat 0x11,0x22,0x33,0x44 -> slave sees writes at 0xFFE,0xFFF,0x000,0x001 with stb_o low one cycle between beats, exactly 4 acks counted.
REQ-038 Backpressure: wdat_valid low 5 cycles before beat 2 -> stb_o low, cyc_o high throughout; beat data order preserved.
REQ-039 Reset mid-burst: rst_i=0 during beat 2 of 4-beat read -> next edge cyc_o=stb_o=0, no done/err; later command runs normally.
REQ-040 Timeout (macro on, TMO_CYC=4): ack never asserted -> err pulses 4 cycles after stb_o rises, cyc_o=0, cmd_ready=1 next cycle.
